// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite loader, renderer and host-side tooling.
package sprite_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAL_R,
        ST_PAL_G,
        ST_PAL_B,
        ST_IMG,
        ST_DONE
    } loader_state_t;

    // Framing bytes of the load stream
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_PAL   = 8'h01;
    localparam logic [7:0] CMD_IMG   = 8'h02;

endpackage

// File: rtl/sprite_bram_writer.sv
// Sprite loader: parses a framed byte stream and issues registered writes
// into the pixel-index BRAM (one byte per pixel) or the 24-bit palette BRAM
// (one write per R,G,B triple).
module sprite_bram_writer
    import sprite_pkg::*;
#(
    parameter int unsigned WIDTH     = 256,
    parameter int unsigned HEIGHT    = 256,
    parameter int unsigned PAL_DEPTH = 256
) (
    input  logic                              pixel_clk_in,
    input  logic                              rst_n_in,
    input  logic [7:0]                        byte_in,
    input  logic                              byte_valid_in,
    output logic                              byte_ready_out,
    input  logic                              abort_in,
    output logic                              img_we_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   img_addr_out,
    output logic [7:0]                        img_data_out,
    output logic                              pal_we_out,
    output logic [$clog2(PAL_DEPTH)-1:0]      pal_addr_out,
    output logic [23:0]                       pal_data_out,
    output logic                              busy_out,
    output logic                              done_out,
    output logic                              error_out
);

    localparam int unsigned IMG_AW = $clog2(WIDTH*HEIGHT);
    localparam int unsigned PAL_AW = $clog2(PAL_DEPTH);
    localparam int unsigned CW     = (IMG_AW > PAL_AW) ? IMG_AW : PAL_AW;

    localparam logic [CW-1:0] IMG_LAST = CW'(WIDTH*HEIGHT - 1);
    localparam logic [CW-1:0] PAL_LAST = CW'(PAL_DEPTH - 1);

    loader_state_t r_state;
    loader_state_t w_next;

    logic [CW-1:0]     r_cnt;
    logic [7:0]        r_red;
    logic [7:0]        r_green;
    logic              r_img_we;
    logic [IMG_AW-1:0] r_img_addr;
    logic [7:0]        r_img_data;
    logic              r_pal_we;
    logic [PAL_AW-1:0] r_pal_addr;
    logic [23:0]       r_pal_data;
    logic              r_busy;
    logic              r_error;

    logic w_accept;
    logic w_go;
    logic w_img_wr;
    logic w_pal_wr;
    logic w_lat_r;
    logic w_lat_g;
    logic w_cnt_clr;
    logic w_cnt_inc;
    logic w_cmd_err;

    assign byte_ready_out = (r_state != ST_DONE);
    assign w_accept       = byte_valid_in && byte_ready_out;
    // An abort in the accepting cycle suppresses every side effect of that byte
    assign w_go           = w_accept && !abort_in;

    assign img_we_out   = r_img_we;
    assign img_addr_out = r_img_addr;
    assign img_data_out = r_img_data;
    assign pal_we_out   = r_pal_we;
    assign pal_addr_out = r_pal_addr;
    assign pal_data_out = r_pal_data;
    assign busy_out     = r_busy;
    assign done_out     = (r_state == ST_DONE);
    assign error_out    = r_error;

    // State register
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= ST_IDLE;
        else           r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        if (abort_in) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (w_accept && byte_in == SYNC_BYTE) w_next = ST_CMD;
                ST_CMD: begin
                    if (w_accept) begin
                        if (byte_in == CMD_PAL)      w_next = ST_PAL_R;
                        else if (byte_in == CMD_IMG) w_next = ST_IMG;
                        else                         w_next = ST_IDLE;
                    end
                end
                ST_PAL_R: if (w_accept) w_next = ST_PAL_G;
                ST_PAL_G: if (w_accept) w_next = ST_PAL_B;
                ST_PAL_B: if (w_accept) w_next = (r_cnt == PAL_LAST) ? ST_DONE : ST_PAL_R;
                ST_IMG:   if (w_accept && r_cnt == IMG_LAST) w_next = ST_DONE;
                ST_DONE:  w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // Per-state actions for the byte accepted this cycle
    always_comb begin
        w_img_wr  = 1'b0;
        w_pal_wr  = 1'b0;
        w_lat_r   = 1'b0;
        w_lat_g   = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        w_cmd_err = 1'b0;
        if (w_go) begin
            unique case (r_state)
                ST_CMD: begin
                    if (byte_in == CMD_PAL || byte_in == CMD_IMG) w_cnt_clr = 1'b1;
                    else                                          w_cmd_err = 1'b1;
                end
                ST_PAL_R: w_lat_r = 1'b1;
                ST_PAL_G: w_lat_g = 1'b1;
                ST_PAL_B: begin
                    w_pal_wr  = 1'b1;
                    w_cnt_inc = (r_cnt != PAL_LAST);
                end
                ST_IMG: begin
                    w_img_wr  = 1'b1;
                    w_cnt_inc = (r_cnt != IMG_LAST);
                end
                default: ;
            endcase
        end
    end

    // Datapath: address counter, RGB latches and registered write ports
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt      <= '0;
            r_red      <= '0;
            r_green    <= '0;
            r_img_we   <= 1'b0;
            r_img_addr <= '0;
            r_img_data <= '0;
            r_pal_we   <= 1'b0;
            r_pal_addr <= '0;
            r_pal_data <= '0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
            if (w_lat_r) r_red   <= byte_in;
            if (w_lat_g) r_green <= byte_in;
            r_img_we <= w_img_wr;
            if (w_img_wr) begin
                r_img_addr <= r_cnt[IMG_AW-1:0];
                r_img_data <= byte_in;
            end
            r_pal_we <= w_pal_wr;
            if (w_pal_wr) begin
                r_pal_addr <= r_cnt[PAL_AW-1:0];
                r_pal_data <= {r_red, r_green, byte_in};
            end
            r_busy  <= (w_next != ST_IDLE);
            r_error <= w_cmd_err;
        end
    end

endmodule

// File: tb/tb_sprite_bram_writer.sv
// Directed bench for sprite_bram_writer: expected writes are queued from the
// stream contents and checked every cycle by one compare process.
module tb_sprite_bram_writer;
    import sprite_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned PD = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        abort = 1'b0;
    logic        img_we;
    logic [3:0]  img_addr;
    logic [7:0]  img_data;
    logic        pal_we;
    logic [7:0]  pal_addr;
    logic [23:0] pal_data;
    logic        busy;
    logic        done;
    logic        err;

    sprite_bram_writer #(.WIDTH(W), .HEIGHT(H), .PAL_DEPTH(PD)) dut (
        .pixel_clk_in  (clk),
        .rst_n_in      (rst_n),
        .byte_in       (byte_in),
        .byte_valid_in (byte_valid),
        .byte_ready_out(byte_ready),
        .abort_in      (abort),
        .img_we_out    (img_we),
        .img_addr_out  (img_addr),
        .img_data_out  (img_data),
        .pal_we_out    (pal_we),
        .pal_addr_out  (pal_addr),
        .pal_data_out  (pal_data),
        .busy_out      (busy),
        .done_out      (done),
        .error_out     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             is_img;
        int unsigned    addr;
        logic [23:0]    data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned done_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned last_pal_addr = 0;
    logic [23:0] last_pal_data = '0;
    int unsigned last_img_addr = 0;
    logic [7:0]  last_img_data = '0;
    bit          prev_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT writes/pulses against the queued expectations each cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 0;
        end else begin
            if (img_we || pal_we) begin
                check("we_exclusive", {31'd0, img_we & pal_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", exp_q.size(), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("write_kind", {31'd0, img_we}, {31'd0, e.is_img});
                    if (img_we) begin
                        check("img_addr", {28'd0, img_addr}, e.addr);
                        check("img_data", {24'd0, img_data}, {8'd0, e.data});
                        last_img_addr = img_addr;
                        last_img_data = img_data;
                    end else begin
                        check("pal_addr", {24'd0, pal_addr}, e.addr);
                        check("pal_data", {8'd0, pal_data}, {8'd0, e.data});
                        last_pal_addr = pal_addr;
                        last_pal_data = pal_data;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                check("done_with_last_write", {31'd0, img_we | pal_we}, 32'd1);
                check("done_after_all_writes", exp_q.size(), 32'd0);
                check("ready_low_in_done", {31'd0, byte_ready}, 32'd0);
                check("busy_in_done", {31'd0, busy}, 32'd1);
            end
            if (prev_done) begin
                check("done_one_cycle", {31'd0, done}, 32'd0);
                check("idle_after_done", {31'd0, busy}, 32'd0);
                check("ready_after_done", {31'd0, byte_ready}, 32'd1);
            end
            if (err) err_cnt++;
            prev_done = done;
        end
    end

    task automatic send(input logic [7:0] b);
        int unsigned guard = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 10) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic gap(input int unsigned n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [23:0] pal_entry(input int unsigned k);
        logic [7:0] r, g, b;
        r = 8'(k);
        g = 8'(k + 1);
        b = 8'(k + 2);
        return {r, g, b};
    endfunction

    task automatic queue_pal();
        wr_t w;
        for (int unsigned k = 0; k < PD; k++) begin
            w.is_img = 1'b0;
            w.addr   = k;
            w.data   = pal_entry(k);
            exp_q.push_back(w);
        end
    endtask

    task automatic queue_img(input logic [7:0] base);
        wr_t w;
        for (int unsigned a = 0; a < W*H; a++) begin
            w.is_img = 1'b1;
            w.addr   = a;
            w.data   = {16'd0, base + 8'(a)};
            exp_q.push_back(w);
        end
    endtask

    task automatic pal_load(input int unsigned max_gap);
        logic [23:0] d;
        send(SYNC_BYTE);
        send(CMD_PAL);
        for (int unsigned k = 0; k < PD; k++) begin
            d = pal_entry(k);
            send(d[23:16]); gap($urandom_range(0, max_gap));
            send(d[15:8]);  gap($urandom_range(0, max_gap));
            send(d[7:0]);   gap($urandom_range(0, max_gap));
        end
    endtask

    task automatic img_load(input logic [7:0] base);
        send(SYNC_BYTE);
        send(CMD_IMG);
        for (int unsigned a = 0; a < W*H; a++) send(base + 8'(a));
    endtask

    task automatic settle_and_check(input string name, input int unsigned exp_done);
        gap(3);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
        check({name, "_done_count"}, done_cnt, exp_done);
    endtask

    initial begin
        int unsigned e0;
        #12;
        // Reset values
        check("rst_ready", {31'd0, byte_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we", {30'd0, img_we, pal_we}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        gap(2);

        // Full palette load, no gaps
        queue_pal();
        pal_load(0);
        settle_and_check("pal", 1);
        check("pal_last_addr", last_pal_addr, 32'd255);
        check("pal_last_data", {8'd0, last_pal_data}, 32'h00FF0001);

        // Image load with a leading junk byte
        queue_img(8'h10);
        send(8'h00);
        img_load(8'h10);
        settle_and_check("img", 2);
        check("img_last_addr", last_img_addr, 32'd15);
        check("img_last_data", {24'd0, last_img_data}, 32'h1F);

        // Unknown command, then a normal image load
        e0 = err_cnt;
        send(SYNC_BYTE);
        check("busy_after_sync", {31'd0, busy}, 32'd1);
        send(8'h07);
        check("error_pulse", {31'd0, err}, 32'd1);
        gap(2);
        check("error_count", err_cnt - e0, 32'd1);
        check("idle_after_error", {31'd0, busy}, 32'd0);
        queue_img(8'h80);
        img_load(8'h80);
        settle_and_check("img2", 3);

        // Palette load with random gaps
        queue_pal();
        pal_load(5);
        settle_and_check("pal_gaps", 4);
        check("pal_gaps_last_data", {8'd0, last_pal_data}, 32'h00FF0001);

        // Abort on the sixth image byte
        for (int unsigned a = 0; a < 5; a++) begin
            wr_t w;
            w.is_img = 1'b1;
            w.addr   = a;
            w.data   = {16'd0, 8'h40 + 8'(a)};
            exp_q.push_back(w);
        end
        send(SYNC_BYTE);
        send(CMD_IMG);
        for (int unsigned a = 0; a < 5; a++) send(8'h40 + 8'(a));
        abort = 1'b1;
        send(8'h45);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_no_write", {31'd0, img_we}, 32'd0);
        settle_and_check("abort", 4);
        check("abort_last_addr", last_img_addr, 32'd4);

        // Asynchronous reset while waiting for the green byte
        send(SYNC_BYTE);
        send(CMD_PAL);
        send(8'h11);
        check("in_pal_g_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, byte_ready}, 32'd1);
        check("arst_pal_data", {8'd0, pal_data}, 32'd0);
        check("arst_img_addr", {28'd0, img_addr}, 32'd0);
        check("arst_pulses", {28'd0, img_we, pal_we, done, err}, 32'd0);
        gap(2);
        @(negedge clk); rst_n = 1'b1;
        gap(1);
        queue_pal();
        pal_load(0);
        settle_and_check("pal_after_rst", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
